// File: rtl/multibank_read_scheduler.sv
// multibank_read_scheduler
//   Shares BANKS single-read-port memory banks between PORTS read requesters.
//   The low address bits pick the bank and the high bits are the row within it.
//   Each bank has its own round-robin arbiter, so requests to different banks
//   are granted in the same cycle. The winning row address is forwarded to the
//   bank. Read data comes back DATA_LAT cycles later. A per-port shift register
//   of {valid, bank tag} remembers which bank each accepted read went to, and
//   that tag steers the bank data back to the requester.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   r_addr       per-port request address {row, bank}
//   r_avalid     per-port request valid
//   r_aready     per-port accept; combinational, same cycle as the request
//   r_dvalid     per-port response valid, DATA_LAT cycles after accept
//   r_data       per-port response data, zero when r_dvalid is low
//   bank_addr    per-bank row address, zero when the bank is not read
//   bank_avalid  per-bank read strobe
//   bank_rdata   per-bank read data, valid DATA_LAT cycles after the strobe
module multibank_read_scheduler #(
  parameter int PORTS      = 3,
  parameter int BANKS      = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_LAT   = 1,
  localparam int BANK_BITS = $clog2(BANKS),
  localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS,
  localparam int PTR_BITS  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORTS-1:0][ADDR_WIDTH-1:0]    r_addr,
  input  logic [PORTS-1:0]                    r_avalid,
  output logic [PORTS-1:0]                    r_aready,
  output logic [PORTS-1:0]                    r_dvalid,
  output logic [PORTS-1:0][DATA_WIDTH-1:0]    r_data,
  output logic [BANKS-1:0][ROW_BITS-1:0]      bank_addr,
  output logic [BANKS-1:0]                    bank_avalid,
  input  logic [BANKS-1:0][DATA_WIDTH-1:0]    bank_rdata
);

  logic [BANKS-1:0][PORTS-1:0]                 req_s;
  logic [BANKS-1:0]                            gnt_any_s;
  logic [BANKS-1:0][PTR_BITS-1:0]              gnt_idx_s;
  logic [BANKS-1:0][PTR_BITS-1:0]              ptr_r;
  logic [PORTS-1:0]                            accept_s;
  logic [PORTS-1:0][DATA_LAT-1:0]              vld_r;
  logic [PORTS-1:0][DATA_LAT-1:0][BANK_BITS-1:0] tag_r;

  // Requesting set of each bank: valid ports whose bank field selects it
  always_comb begin
    req_s = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int p = 0; p < PORTS; p++) begin
        req_s[b][p] = r_avalid[p] & (r_addr[p][BANK_BITS-1:0] == BANK_BITS'(b));
      end
    end
  end

  // Round-robin search per bank, starting one past the last granted port
  always_comb begin
    logic [PTR_BITS-1:0] idx_v;
    logic                hit_v;
    gnt_any_s = '0;
    gnt_idx_s = '0;
    idx_v     = '0;
    hit_v     = 1'b0;
    for (int b = 0; b < BANKS; b++) begin
      for (int k = 1; k <= PORTS; k++) begin
        idx_v        = PTR_BITS'((int'(ptr_r[b]) + k) % PORTS);
        // Only the first requester in search order takes the grant
        hit_v        = req_s[b][idx_v] & ~gnt_any_s[b];
        gnt_idx_s[b] = hit_v ? idx_v : gnt_idx_s[b];
        gnt_any_s[b] = gnt_any_s[b] | hit_v;
      end
    end
    // No grants at all while reset is held
    gnt_any_s = gnt_any_s & {BANKS{~rst}};
  end

  // Requester accept and bank-side strobe/row drive
  always_comb begin
    logic [BANK_BITS-1:0] bsel_v;
    r_aready    = '0;
    bank_addr   = '0;
    bank_avalid = gnt_any_s;
    bsel_v      = '0;
    for (int p = 0; p < PORTS; p++) begin
      bsel_v      = r_addr[p][BANK_BITS-1:0];
      r_aready[p] = gnt_any_s[bsel_v] & (gnt_idx_s[bsel_v] == PTR_BITS'(p));
    end
    for (int b = 0; b < BANKS; b++) begin
      bank_addr[b] = gnt_any_s[b] ? r_addr[gnt_idx_s[b]][ADDR_WIDTH-1:BANK_BITS]
                                  : {ROW_BITS{1'b0}};
    end
  end

  assign accept_s = r_avalid & r_aready;

  // Arbiter pointers: remember the last granted port, hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANKS; b++) begin
        ptr_r[b] <= PTR_BITS'(PORTS - 1);
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (gnt_any_s[b]) begin
          ptr_r[b] <= gnt_idx_s[b];
        end
      end
    end
  end

  // Return pipeline: carries {valid, bank tag} for DATA_LAT cycles per port
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= '0;
      tag_r <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        vld_r[p][0] <= accept_s[p];
        tag_r[p][0] <= r_addr[p][BANK_BITS-1:0];
        for (int s = 1; s < DATA_LAT; s++) begin
          vld_r[p][s] <= vld_r[p][s-1];
          tag_r[p][s] <= tag_r[p][s-1];
        end
      end
    end
  end

  // Response steering: last pipeline stage selects the bank data
  always_comb begin
    r_dvalid = '0;
    r_data   = '0;
    for (int p = 0; p < PORTS; p++) begin
      r_dvalid[p] = vld_r[p][DATA_LAT-1];
      r_data[p]   = vld_r[p][DATA_LAT-1] ? bank_rdata[tag_r[p][DATA_LAT-1]]
                                         : {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_multibank_read_scheduler.sv
module tb_multibank_read_scheduler;

  logic clk;
  int   cyc;
  int   checks;
  int   errors;

  // Instance with DATA_LAT = 1
  logic             rst1;
  logic [2:0][3:0]  r_addr1;
  logic [2:0]       r_avalid1;
  logic [2:0]       r_aready1;
  logic [2:0]       r_dvalid1;
  logic [2:0][31:0] r_data1;
  logic [3:0][1:0]  bank_addr1;
  logic [3:0]       bank_avalid1;

  // Instance with DATA_LAT = 3
  logic             rst3;
  logic [2:0][3:0]  r_addr3;
  logic [2:0]       r_avalid3;
  logic [2:0]       r_aready3;
  logic [2:0]       r_dvalid3;
  logic [2:0][31:0] r_data3;
  logic [3:0][1:0]  bank_addr3;
  logic [3:0]       bank_avalid3;

  logic [3:0][31:0] bank_tbl;

  typedef struct {
    int          inst;
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  multibank_read_scheduler #(.PORTS(3), .BANKS(4), .ADDR_WIDTH(4), .DATA_WIDTH(32), .DATA_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst1), .r_addr(r_addr1), .r_avalid(r_avalid1), .r_aready(r_aready1),
    .r_dvalid(r_dvalid1), .r_data(r_data1), .bank_addr(bank_addr1), .bank_avalid(bank_avalid1),
    .bank_rdata(bank_tbl)
  );

  multibank_read_scheduler #(.PORTS(3), .BANKS(4), .ADDR_WIDTH(4), .DATA_WIDTH(32), .DATA_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst3), .r_addr(r_addr3), .r_avalid(r_avalid3), .r_aready(r_aready3),
    .r_dvalid(r_dvalid3), .r_data(r_data3), .bank_addr(bank_addr3), .bank_avalid(bank_avalid3),
    .bank_rdata(bank_tbl)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, one tick per rising edge
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pop every response due this cycle and compare against the DUT outputs
  task automatic check_resp(input int w);
    logic [2:0]       ev;
    logic [2:0][31:0] ed;
    logic [2:0]       dv;
    logic [2:0][31:0] dd;
    ev = '0;
    ed = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].inst == w && sb[i].due == cyc) begin
        ev[sb[i].port] = 1'b1;
        ed[sb[i].port] = sb[i].data;
        sb.delete(i);
      end
    end
    dv = (w == 0) ? r_dvalid1 : r_dvalid3;
    dd = (w == 0) ? r_data1 : r_data3;
    checks++;
    assert (dv === ev) else begin
      errors++;
      $error("FAIL r_dvalid inst%0d cyc%0d: got %b expected %b", w, cyc, dv, ev);
    end
    for (int p = 0; p < 3; p++) begin
      checks++;
      assert (dd[p] === ed[p]) else begin
        errors++;
        $error("FAIL r_data[%0d] inst%0d cyc%0d: got %h expected %h", p, w, cyc, dd[p], ed[p]);
      end
    end
  endtask

  // Response monitor, sampled just after each rising edge
  always @(posedge clk) begin
    #2;
    check_resp(0);
    check_resp(1);
  end

  // One directed cycle: drive, check the same-cycle outputs, record expected responses
  task automatic step(input int w, input logic rs, input logic [2:0] av, input logic [2:0][3:0] ad,
                      input logic [2:0] ear, input logic [3:0] ebv, input logic [3:0][1:0] eba,
                      input string tag);
    logic [2:0]      ar;
    logic [3:0]      bv;
    logic [3:0][1:0] ba;
    @(negedge clk);
    if (w == 0) begin
      rst1 = rs; r_avalid1 = av; r_addr1 = ad; r_avalid3 = '0;
    end else begin
      rst3 = rs; r_avalid3 = av; r_addr3 = ad; r_avalid1 = '0;
    end
    if (rs) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].inst == w) sb.delete(i);
      end
    end
    #1;
    ar = (w == 0) ? r_aready1 : r_aready3;
    bv = (w == 0) ? bank_avalid1 : bank_avalid3;
    ba = (w == 0) ? bank_addr1 : bank_addr3;
    checks++;
    assert (ar === ear) else begin
      errors++;
      $error("FAIL %s r_aready: got %b expected %b", tag, ar, ear);
    end
    checks++;
    assert (bv === ebv) else begin
      errors++;
      $error("FAIL %s bank_avalid: got %b expected %b", tag, bv, ebv);
    end
    checks++;
    assert (ba === eba) else begin
      errors++;
      $error("FAIL %s bank_addr: got %h expected %h", tag, ba, eba);
    end
    for (int p = 0; p < 3; p++) begin
      if (ear[p]) sb.push_back('{w, p, bank_tbl[ad[p][1:0]], cyc + ((w == 0) ? 1 : 3)});
    end
  endtask

  task automatic idle(input int w, input int n);
    for (int i = 0; i < n; i++) step(w, 1'b0, 3'b000, 12'h000, 3'b000, 4'b0000, 8'h00, "idle");
  endtask

  initial begin
    logic [3:0][1:0] eba;
    int              g;
    checks    = 0;
    errors    = 0;
    bank_tbl  = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
    rst1      = 1'b1;
    rst3      = 1'b1;
    r_addr1   = '0;
    r_avalid1 = '0;
    r_addr3   = '0;
    r_avalid3 = '0;

    // Reset holds everything quiet even with requests present
    step(0, 1'b1, 3'b111, {4'h2, 4'h1, 4'h0}, 3'b000, 4'b0000, 8'h00, "rst_lat1");
    step(1, 1'b1, 3'b111, {4'h2, 4'h1, 4'h0}, 3'b000, 4'b0000, 8'h00, "rst_lat3");

    // Single request to bank1 row1
    step(0, 1'b0, 3'b001, {4'h0, 4'h0, 4'h5}, 3'b001, 4'b0010, {2'd0, 2'd0, 2'd1, 2'd0}, "single");
    idle(0, 1);

    // Three ports to three different banks in the same cycle
    step(0, 1'b0, 3'b111, {4'h2, 4'h1, 4'h0}, 3'b111, 4'b0111, 8'h00, "parallel");
    idle(0, 1);

    // All three ports on bank2: rotation 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      g = k % 3;
      eba = '0;
      eba[2] = 2'(g);
      step(0, 1'b0, 3'b111, {4'hA, 4'h6, 4'h2}, 3'(1 << g), 4'b0100, eba, "fair");
    end
    idle(0, 1);

    // Pointer holds over idle cycles: port1 wins bank3, then port2 before port0
    step(0, 1'b0, 3'b010, {4'h0, 4'h7, 4'h0}, 3'b010, 4'b1000, {2'd1, 2'd0, 2'd0, 2'd0}, "hold_p1");
    idle(0, 5);
    step(0, 1'b0, 3'b101, {4'hF, 4'h0, 4'hB}, 3'b100, 4'b1000, {2'd3, 2'd0, 2'd0, 2'd0}, "hold_p2");
    step(0, 1'b0, 3'b101, {4'hF, 4'h0, 4'hB}, 3'b001, 4'b1000, {2'd2, 2'd0, 2'd0, 2'd0}, "hold_p0");

    // Loser drops its request without a grant; next search starts after port1
    step(0, 1'b0, 3'b110, {4'h4, 4'h8, 4'h0}, 3'b010, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, "drop_a");
    step(0, 1'b0, 3'b001, {4'h0, 4'h0, 4'hC}, 3'b001, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd3}, "drop_b");
    idle(0, 2);

    // DATA_LAT=3: back-to-back reads from port0 across banks 0,1,2
    step(1, 1'b0, 3'b001, {4'h0, 4'h0, 4'h4}, 3'b001, 4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, "lat3_a");
    step(1, 1'b0, 3'b001, {4'h0, 4'h0, 4'h5}, 3'b001, 4'b0010, {2'd0, 2'd0, 2'd1, 2'd0}, "lat3_b");
    step(1, 1'b0, 3'b001, {4'h0, 4'h0, 4'h6}, 3'b001, 4'b0100, {2'd0, 2'd1, 2'd0, 2'd0}, "lat3_c");
    idle(1, 4);

    // Reset while a read is in flight: its response must never appear
    step(1, 1'b0, 3'b001, {4'h0, 4'h0, 4'h7}, 3'b001, 4'b1000, {2'd1, 2'd0, 2'd0, 2'd0}, "mid_grant");
    step(1, 1'b1, 3'b011, {4'h0, 4'hB, 4'h7}, 3'b000, 4'b0000, 8'h00, "mid_rst");
    // Held requests after reset; pointer back to PORTS-1 so port0 wins bank3
    step(1, 1'b0, 3'b011, {4'h0, 4'hB, 4'h7}, 3'b001, 4'b1000, {2'd1, 2'd0, 2'd0, 2'd0}, "post_rst");
    idle(1, 5);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multibank_read_scheduler.md
Name: multibank_read_scheduler

Overview:
Shares a set of single-read-port memory banks between several read requesters. The low address bits select the bank. Each bank has its own round-robin arbiter that picks one requester per cycle. Granted addresses are forwarded to the banks, and each bank's response is returned to the requester that issued it after a fixed latency, using a per-port bank-tag pipeline. The block sits between the read clients and a bank array of pseudo-dual-port memories.

Parameters:
- PORTS, 3: number of read requesters (>=1).
- BANKS, 4: number of banks. Power of two, >=2.
- ADDR_WIDTH, 4: requester address width. Must be > BANK_BITS.
- DATA_WIDTH, 32: data word width.
- DATA_LAT, 1: bank read latency in cycles (>=1).
- BANK_BITS, localparam = $clog2(BANKS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- r_addr  in  [PORTS][ADDR_WIDTH]  request address. Bank = addr[BANK_BITS-1:0]; row = addr[ADDR_WIDTH-1:BANK_BITS].
- r_avalid  in  [PORTS]  request valid.
- r_aready  out  [PORTS]  request accepted this cycle.
- r_dvalid  out  [PORTS]  response valid.
- r_data  out  [PORTS][DATA_WIDTH]  response data.
- bank_addr  out  [BANKS][ADDR_WIDTH-BANK_BITS]  row address to each bank.
- bank_avalid  out  [BANKS]  read strobe to each bank.
- bank_rdata  in  [BANKS][DATA_WIDTH]  bank read data, valid DATA_LAT cycles after the strobe.

Behaviour:
- Handshake: a transfer occurs when r_avalid[i] & r_aready[i]. r_aready is combinational from r_avalid, r_addr and arbiter state, in the same cycle.
- A requester must hold r_addr stable while r_avalid is high and r_aready is low.
- Per bank b, requesting set = {i : r_avalid[i] and bank(r_addr[i]) == b}.
- Round-robin per bank: ptr[b] holds the last granted port. Search order is ptr[b]+1, ptr[b]+2, … modulo PORTS. The first port in the requesting set is granted.
- ptr[b] updates at the clock edge only when bank b grants; otherwise it holds.
- Reset value of every ptr = PORTS-1, so port 0 wins first.
- Each port targets exactly one bank, so it receives at most one grant per cycle.
- Requests to different banks are granted in the same cycle with no interaction.
- bank_avalid[b] = 1 iff bank b grants. bank_addr[b] = row of the granted port; 0 when no grant.
- Return pipeline: per port, a DATA_LAT-deep shift register of {valid, bank tag[BANK_BITS]}. Stage 0 loads {r_avalid[i]&r_aready[i], bank(r_addr[i])} each cycle.
- r_dvalid[i] = valid bit of the last stage. It asserts exactly DATA_LAT cycles after the accepting edge.
- r_data[i] = bank_rdata[tag] when r_dvalid[i]; otherwise 0.
- Back-to-back accepts from one port give back-to-back responses in order, with no bubbles.
- While rst is high: r_aready = 0, bank_avalid = 0, bank_addr = 0. At the edge, all pipeline valid bits clear (r_dvalid = 0, r_data = 0) and ptrs return to PORTS-1.
- Reset mid-operation: in-flight responses are dropped and never produce r_dvalid. A request held across reset deassertion is arbitrated normally on the first cycle after reset.
- Dropping r_avalid without a grant is legal: no state change and no response.

Test Plan:
Defaults PORTS=3, BANKS=4, ADDR_WIDTH=4, DATA_LAT=1 unless noted.
1. Single request: port0 r_addr=0x5 (bank1, row1) for one cycle. Expect r_aready[0]=1, bank_avalid=4'b0010, bank_addr[1]=1 in the same cycle. Next cycle r_dvalid=3'b001, r_data[0]=bank_rdata[1] (drive 0xDEADBEEF). Other r_data = 0.
2. Parallel banks: ports 0, 1, 2 request 0x0, 0x1, 0x2 together. Expect r_aready=3'b111, bank_avalid=4'b0111. One cycle later, each r_data[i] = bank_rdata[i].
3. Conflict fairness: all three ports hold r_avalid with addresses 0x2, 0x6, 0xA (all bank2) for 6 cycles. Expect grant order 0,1,2,0,1,2 and bank_addr[2] sequence 0,1,2,0,1,2. Each port's r_dvalid is one-hot one cycle after its grant.
4. Pointer hold: port1 alone wins bank3 (ptr[3]=1). Idle 5 cycles, then ports 0 and 2 request bank3. Expect port2 granted first, then port0.
5. DATA_LAT=3: port0 issues 0x4, 0x5, 0x6 on consecutive cycles with bank_rdata set per bank. Expect r_dvalid[0] high on cycles 3, 4, 5 with data from banks 0, 1, 2 in order.
6. Reset mid-flight (DATA_LAT=3): grant on cycle 0, rst on cycle 1. Expect r_dvalid to stay 0 throughout. After rst drops, the first accepted request returns normally DATA_LAT cycles later.
